ysyx_23060072_lsu_stage: RTL

Memory-access stage of the RV32E pipeline, fed by the EX→LSU pipeline registers and feeding the WB stage.
- Computes the effective address, issues one load or store on a valid/ready data-memory port, and aligns/extends load data.
- Registers the writeback payload for WB.
- Stalls the front of the pipeline via lsu_hold_flag_o while an access is outstanding.

---
 rtl/ysyx_23060072_lsu_stage_if.sv | 21 ++
 rtl/ysyx_23060072_lsu_stage.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060072_lsu_stage_if.sv
// Data-memory port of the LSU stage: valid/ready request channel plus rvalid response channel.
interface ysyx_23060072_lsu_stage_if;
  logic        mem_valid_o;
  logic        mem_ready_i;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_wstrb_o;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  modport master (
    output mem_valid_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
    input  mem_ready_i, mem_rvalid_i, mem_rdata_i
  );

  modport slave (
    input  mem_valid_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
    output mem_ready_i, mem_rvalid_i, mem_rdata_i
  );
endinterface

// File: rtl/ysyx_23060072_lsu_stage.sv
// RV32E memory-access stage: one load/store per instruction over a valid/ready port, registered WB payload.
// Optional misaligned-access trap enabled by defining YSYX_23060072_LSU_MISALIGN_CHK_EN.
module ysyx_23060072_lsu_stage #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_i,
  input  logic        load_flag_i,
  input  logic        store_flag_i,
  input  logic [1:0]  LSU_type_i,
  input  logic        LSU_signed_i,
  input  logic [31:0] operand_a_i,
  input  logic [31:0] operand_b_i,
  input  logic [31:0] operand_imm_i,
  input  logic [31:0] wb_data_ex_i,
  input  logic [4:0]  wb_addr_i,
  input  logic        wb_flag_i,
  ysyx_23060072_lsu_stage_if.master mem,
  output logic        lsu_hold_flag_o,
  output logic        bus_error_o,
  output logic [31:0] pc_o,
  output logic [4:0]  wb_addr_o,
  output logic        wb_flag_o,
  output logic [31:0] wb_data_o
);
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  // MIS is the one-cycle completion of a trapped misaligned access.
  typedef enum logic [1:0] {IDLE, REQ, WAIT, MIS} state_t;
  state_t state, state_nxt;

  logic        acc, misalign, timeout, done;
  logic [31:0] ea, st_wdata;
  logic [1:0]  off;
  logic [3:0]  st_wstrb;
  logic [CNT_W-1:0] cnt;

  logic [31:0] lat_ea, lat_wdata, lat_pc, lat_wb_data;
  logic [3:0]  lat_wstrb;
  logic [1:0]  lat_type;
  logic [4:0]  lat_wb_addr;
  logic        lat_we, lat_sgn, lat_wb_flag;

  logic [4:0]  shamt;
  logic [31:0] rd_sh, ld_data;

  assign acc = load_flag_i | store_flag_i;
  assign ea  = operand_a_i + operand_imm_i;
  assign off = ea[1:0];

`ifdef YSYX_23060072_LSU_MISALIGN_CHK_EN
  assign misalign = ((LSU_type_i == 2'b01) && off[0]) || (LSU_type_i[1] && (off != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    st_wdata = operand_b_i;
    st_wstrb = 4'b1111;
    case (LSU_type_i)
      2'b00: begin
        st_wdata = {4{operand_b_i[7:0]}};
        st_wstrb = 4'b0001 << off;
      end
      2'b01: begin
        st_wdata = {2{operand_b_i[15:0]}};
        st_wstrb = 4'b0011 << {off[1], 1'b0};
      end
      default: ;
    endcase
  end

  assign timeout = (TIMEOUT_CYCLES != 0) && (state == WAIT) && !mem.mem_rvalid_i && (cnt == CNT_LAST);
  assign done    = (state == WAIT) && (mem.mem_rvalid_i || timeout);

  assign lsu_hold_flag_o = ((state == IDLE) && acc) || (state == REQ) || ((state == WAIT) && !done);

  assign mem.mem_valid_o = (state == REQ);
  assign mem.mem_we_o    = lat_we;
  assign mem.mem_addr_o  = lat_ea;
  assign mem.mem_wdata_o = lat_wdata;
  assign mem.mem_wstrb_o = lat_wstrb;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (acc) state_nxt = misalign ? MIS : REQ;
      REQ:     if (mem.mem_ready_i) state_nxt = WAIT;
      WAIT:    if (done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Halves pick lanes by off[1] only, so off=3 still reads lanes [3:2].
  always_comb begin
    shamt = {lat_ea[1:0], 3'b000};
    if (lat_type == 2'b01) shamt = {lat_ea[1], 4'b0000};
    rd_sh = mem.mem_rdata_i >> shamt;
    case (lat_type)
      2'b00:   ld_data = {{24{lat_sgn & rd_sh[7]}}, rd_sh[7:0]};
      2'b01:   ld_data = {{16{lat_sgn & rd_sh[15]}}, rd_sh[15:0]};
      default: ld_data = rd_sh;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt         <= '0;
      lat_ea      <= '0;
      lat_we      <= 1'b0;
      lat_wdata   <= '0;
      lat_wstrb   <= '0;
      lat_type    <= '0;
      lat_sgn     <= 1'b0;
      lat_pc      <= '0;
      lat_wb_addr <= '0;
      lat_wb_flag <= 1'b0;
      lat_wb_data <= '0;
      pc_o        <= '0;
      wb_addr_o   <= '0;
      wb_flag_o   <= 1'b0;
      wb_data_o   <= '0;
      bus_error_o <= 1'b0;
    end else begin
      bus_error_o <= 1'b0;
      case (state)
        IDLE: begin
          if (acc) begin
            lat_ea      <= ea;
            lat_we      <= store_flag_i;
            lat_wdata   <= st_wdata;
            lat_wstrb   <= store_flag_i ? st_wstrb : 4'b0000;
            lat_type    <= LSU_type_i;
            lat_sgn     <= LSU_signed_i;
            lat_pc      <= pc_i;
            lat_wb_addr <= wb_addr_i;
            lat_wb_flag <= wb_flag_i;
            lat_wb_data <= wb_data_ex_i;
            wb_flag_o   <= 1'b0;
          end else begin
            pc_o      <= pc_i;
            wb_addr_o <= wb_addr_i;
            wb_flag_o <= wb_flag_i;
            wb_data_o <= wb_data_ex_i;
          end
        end
        REQ: begin
          wb_flag_o <= 1'b0;
          if (mem.mem_ready_i) cnt <= '0;
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (done) begin
            pc_o        <= lat_pc;
            wb_addr_o   <= lat_wb_addr;
            wb_flag_o   <= lat_wb_flag;
            wb_data_o   <= lat_we ? lat_wb_data : (timeout ? 32'h0 : ld_data);
            bus_error_o <= timeout;
          end else begin
            wb_flag_o <= 1'b0;
          end
        end
        default: begin
          pc_o        <= lat_pc;
          wb_addr_o   <= lat_wb_addr;
          wb_flag_o   <= 1'b0;
          bus_error_o <= 1'b1;
        end
      endcase
    end
  end
endmodule
